// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake and serial-line status signals for uart_tx_buffered.
// master drives strobe/data; slave is the transmitter.
interface uart_tx_buffered_if;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD;
  logic       TxD_busy;
  logic       TxD_idle;
  logic       TxD_overflow;

  modport master (
    output TxD_start, TxD_data,
    input  TxD, TxD_busy, TxD_idle, TxD_overflow
  );

  modport slave (
    input  TxD_start, TxD_data,
    output TxD, TxD_busy, TxD_idle, TxD_overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small write FIFO; each bit lasts ClkFrequency/Baud
// clocks and queued bytes go out back-to-back with no idle gap between frames.
module uart_tx_buffered #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int FifoDepth    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  uart_tx_buffered_if.slave txIf
);
  localparam int Div  = ClkFrequency / Baud;
  localparam int PtrW = (FifoDepth > 2) ? $clog2(FifoDepth) : 1;
  localparam int CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [PtrW:0]   FullCount = (PtrW+1)'(FifoDepth);
  localparam logic [CntW-1:0] DivLast   = CntW'(Div - 1);

  if (Div < 2 || FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gBadParams
    $fatal(1, "uart_tx_buffered: need ClkFrequency/Baud >= 2 and FifoDepth a power of 2 >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, stateNext;
  logic [2:0]      bitIdx, bitIdxNext;
  logic [CntW-1:0] bitCnt, bitCntNext;
  logic [7:0]      shiftReg, shiftNext;
  logic            txd, txdNext;

  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [PtrW:0]   count;
  logic            overflow;
  logic            fifoEmpty, fifoFull, wrEn, pop, bitWrap;

  // Full is judged on the registered count, so a pop on the same edge never frees a slot early.
  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FullCount);
  assign wrEn      = txIf.TxD_start && !fifoFull;
  assign bitWrap   = (bitCnt == DivLast);

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= txIf.TxD_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({wrEn, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (txIf.TxD_start && fifoFull) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      bitIdx   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= stateNext;
      bitIdx   <= bitIdxNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      txd      <= txdNext;
    end
  end

  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    pop        = 1'b0;
    bitCntNext = bitWrap ? '0 : bitCnt + 1'b1;
    case (state)
      IDLE: begin
        bitCntNext = '0;
        if (!fifoEmpty) begin
          stateNext = START;
          pop       = 1'b1;
          shiftNext = mem[rdPtr];
        end
      end
      START: begin
        if (bitWrap) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (bitWrap) begin
          if (bitIdx == 3'd7) stateNext = STOP;
          else                bitIdxNext = bitIdx + 1'b1;
        end
      end
      STOP: begin
        if (bitWrap) begin
          if (!fifoEmpty) begin
            stateNext = START;
            pop       = 1'b1;
            shiftNext = mem[rdPtr];
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Line level is decoded from the next state so TxD is a plain register aligned with it.
  always_comb begin
    txdNext = 1'b1;
    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftNext[bitIdxNext];
      default: txdNext = 1'b1;
    endcase
  end

  assign txIf.TxD          = txd;
  assign txIf.TxD_busy     = fifoFull;
  assign txIf.TxD_idle     = (state == IDLE) && fifoEmpty;
  assign txIf.TxD_overflow = overflow;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: queue/countdown reference model checked every
// clock, plus a line decoder scoring received bytes against directed and random traffic.
module tb_uart_tx_buffered;
  localparam int Div       = 10;
  localparam int Depth     = 4;
  localparam int FrameClks = 10 * Div;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  uart_tx_buffered_if txIf();

  uart_tx_buffered #(
    .ClkFrequency(1000000),
    .Baud        (100000),
    .FifoDepth   (Depth)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .txIf  (txIf)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes waiting in the buffer, and clocks left in the frame on the line.
  logic [7:0] mQ[$];
  logic [7:0] sentQ[$];
  int         mRemain = 0;
  logic [9:0] mFrame  = '1;
  logic       mOvf    = 1'b0;

  always @(posedge clk or negedge resetn) begin
    int   sz;
    bit   doPop;
    logic [7:0] b;
    if (!resetn) begin
      mQ.delete();
      mRemain = 0;
      mOvf    = 1'b0;
    end else begin
      sz    = mQ.size();
      doPop = (sz > 0) && (mRemain <= 1);
      if (txIf.TxD_start && sz == Depth) mOvf = 1'b1;
      if (mRemain > 0) mRemain--;
      if (doPop) begin
        b       = mQ.pop_front();
        mFrame  = {1'b1, b, 1'b0};
        mRemain = FrameClks;
        sentQ.push_back(b);
      end
      if (txIf.TxD_start && sz < Depth) mQ.push_back(txIf.TxD_data);
    end
  end

  // Per-clock comparison against the model, and a mid-bit sampling receiver.
  logic [7:0] rxQ[$];
  bit         rxActive = 0;
  int         rxCnt    = 0;
  logic [7:0] rxByte   = '0;

  always @(negedge clk) begin
    logic expTxd;
    expTxd = (mRemain > 0) ? mFrame[(FrameClks - mRemain) / Div] : 1'b1;
    check("line", 32'(txIf.TxD), 32'(expTxd));
    check("busy", 32'(txIf.TxD_busy), 32'(mQ.size() == Depth));
    check("idle", 32'(txIf.TxD_idle), 32'(mRemain == 0 && mQ.size() == 0));
    check("overflow", 32'(txIf.TxD_overflow), 32'(mOvf));
    if (!resetn) begin
      rxActive = 0;
      rxCnt    = 0;
    end else if (!rxActive) begin
      if (txIf.TxD === 1'b0) begin
        rxActive = 1;
        rxCnt    = 0;
      end
    end else begin
      rxCnt++;
      if (rxCnt == Div/2 + 9*Div) begin
        check("stopBit", 32'(txIf.TxD), 32'(1));
        rxQ.push_back(rxByte);
        rxActive = 0;
      end else if (rxCnt > Div/2 && (rxCnt - Div/2) % Div == 0) begin
        rxByte[(rxCnt - Div/2) / Div - 1] = txIf.TxD;
      end
    end
  end

  logic [7:0] expQ[$];

  task automatic drive(input bit s, input logic [7:0] d);
    txIf.TxD_start = s;
    txIf.TxD_data  = d;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (txIf.TxD_idle !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idleReached", 32'(txIf.TxD_idle), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrames(input string tag);
    check({tag, "_count"}, 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      check(tag, 32'(rxQ[i]), 32'(expQ[i]));
    rxQ.delete();
    sentQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_txd"}, 32'(txIf.TxD), 32'(1));
    check({tag, "_busy"}, 32'(txIf.TxD_busy), 32'(0));
    check({tag, "_idle"}, 32'(txIf.TxD_idle), 32'(1));
    check({tag, "_ovf"}, 32'(txIf.TxD_overflow), 32'(0));
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 resetn = 1'b0;
    drive(0, 8'h00);
    #1 checkResetOutputs("rst");
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    rxQ.delete();
    sentQ.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a5Bits[10];
    int n;
    int r;
    int burst;
    a5Bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    drive(0, 8'h00);
    #1 resetn = 1'b0;
    #1 checkResetOutputs("por");
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    // Single byte into an idle transmitter.
    drive(1, 8'hA5);
    @(negedge clk);
    drive(0, 8'h00);
    check("a5_beforeFall", 32'(txIf.TxD), 32'(1));
    @(negedge clk);
    for (int c = 0; c < FrameClks; c++) begin
      if (c % Div == 0 || c % Div == Div - 1)
        check("a5_bit", 32'(txIf.TxD), 32'(a5Bits[c / Div]));
      if (c == 0 || c == FrameClks - 1)
        check("a5_busyFrame", 32'(txIf.TxD_idle), 32'(0));
      @(negedge clk);
    end
    check("a5_idleAfter", 32'(txIf.TxD_idle), 32'(1));
    waitIdle(50);
    expQ.push_back(8'hA5);
    checkFrames("a5_rx");

    // Three bytes on consecutive clocks: contiguous frames, never idle in between.
    drive(1, 8'h01); @(negedge clk);
    drive(1, 8'h02); @(negedge clk);
    drive(1, 8'h03); @(negedge clk);
    drive(0, 8'h00);
    for (int c = 2; c <= 3 * FrameClks; c++) begin
      check("b2b_notIdle", 32'(txIf.TxD_idle), 32'(0));
      @(negedge clk);
    end
    check("b2b_idleAfter", 32'(txIf.TxD_idle), 32'(1));
    waitIdle(50);
    expQ.push_back(8'h01); expQ.push_back(8'h02); expQ.push_back(8'h03);
    checkFrames("b2b_rx");

    // Six writes on consecutive clocks: busy after the fifth, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) check("burst_busy", 32'(txIf.TxD_busy), 32'((i - 1) >= 4));
      drive(1, 8'(8'h10 + i));
    end
    @(negedge clk);
    drive(0, 8'h00);
    check("burst_busyFull", 32'(txIf.TxD_busy), 32'(1));
    check("burst_ovf", 32'(txIf.TxD_overflow), 32'(1));
    waitIdle(700);
    check("burst_ovfSticky", 32'(txIf.TxD_overflow), 32'(1));
    for (int i = 0; i < 5; i++) expQ.push_back(8'(8'h10 + i));
    checkFrames("burst_rx");
    applyReset();

    // Full FIFO with a write held across the STOP->START pop edge.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h20 + i));
      @(negedge clk);
    end
    drive(1, 8'h77);
    n = 0;
    while (txIf.TxD_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    drive(0, 8'h00);
    check("popEdge_busyDrop", 32'(txIf.TxD_busy), 32'(0));
    check("popEdge_ovf", 32'(txIf.TxD_overflow), 32'(1));
    @(negedge clk);
    drive(1, 8'h30);
    @(negedge clk);
    drive(0, 8'h00);
    check("popEdge_oneFree", 32'(txIf.TxD_busy), 32'(1));
    waitIdle(700);
    for (int i = 0; i < 5; i++) expQ.push_back(8'(8'h20 + i));
    expQ.push_back(8'h30);
    checkFrames("popEdge_rx");
    applyReset();

    // Reset during data bit 3 of 0x55 with two more bytes queued.
    drive(1, 8'h55); @(negedge clk);
    drive(1, 8'hAA); @(negedge clk);
    drive(1, 8'hBB); @(negedge clk);
    drive(0, 8'h00);
    repeat (41) @(negedge clk);
    check("midRst_bit3", 32'(txIf.TxD), 32'(0));
    #2 resetn = 1'b0;
    #1 checkResetOutputs("midRst");
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    for (int c = 0; c < 3 * FrameClks; c++) begin
      @(negedge clk);
      if (c % 50 == 0) begin
        check("midRst_idle", 32'(txIf.TxD_idle), 32'(1));
        check("midRst_line", 32'(txIf.TxD), 32'(1));
      end
    end
    checkFrames("midRst_rx");

    // Data input churning during a frame.
    @(negedge clk);
    drive(1, 8'h3C);
    @(negedge clk);
    drive(0, 8'($urandom));
    repeat (FrameClks + 10) begin
      @(negedge clk);
      txIf.TxD_data = 8'($urandom);
    end
    waitIdle(50);
    expQ.push_back(8'h3C);
    checkFrames("churn_rx");

    // Random traffic: sparse writes with occasional bursts.
    burst = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (burst > 0) begin
        drive(1, 8'($urandom));
        burst--;
      end else if (r < 3) begin
        drive(1, 8'($urandom));
      end else if (r == 3) begin
        burst = int'($urandom_range(2, 7));
        drive(0, 8'($urandom));
      end else begin
        drive(0, 8'($urandom));
      end
    end
    @(negedge clk);
    drive(0, 8'h00);
    waitIdle(1000);
    expQ = sentQ;
    checkFrames("rand_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
